// File: rtl/sequenciador_motor_if.sv
// sequenciador_motor_if: command levels in, H-bridge drives and status out
interface sequenciador_motor_if;
    logic       Frente;
    logic       FrenteAtras;
    logic       AtrasFrente;
    logic       me_fwd;
    logic       me_rev;
    logic       md_fwd;
    logic       md_rev;
    logic       ocupado;
    logic [2:0] estado;
    modport master (
        output Frente, FrenteAtras, AtrasFrente,
        input  me_fwd, me_rev, md_fwd, md_rev, ocupado, estado
    );
    modport slave (
        input  Frente, FrenteAtras, AtrasFrente,
        output me_fwd, me_rev, md_fwd, md_rev, ocupado, estado
    );
endinterface

// File: rtl/sequenciador_motor.sv
// sequenciador_motor: timed H-bridge sequencer for escape manoeuvres
// SEQ_DEADTIME_EN defined inserts a PAUSA dead-time phase on every direction reversal
module sequenciador_motor #(
    parameter int CNT_W   = 8,
    parameter int T_RE    = 50,
    parameter int T_GIRO  = 30,
    parameter int T_AV    = 20,
    parameter int T_MORTO = 4
) (
    input logic clk,
    input logic reset,
    sequenciador_motor_if.slave bus
);
    typedef enum logic [2:0] {
        PARADO = 3'd0,
        FRENTE = 3'd1,
        PAUSA  = 3'd2,
        RE     = 3'd3,
        GIRO   = 3'd4,
        AVANCO = 3'd5
    } state_t;

    // A phase of T cycles loads T-1; a length of 0 is treated as 1
    localparam logic [CNT_W-1:0] L_RE    = CNT_W'((T_RE    > 1) ? T_RE    - 1 : 0);
    localparam logic [CNT_W-1:0] L_GIRO  = CNT_W'((T_GIRO  > 1) ? T_GIRO  - 1 : 0);
    localparam logic [CNT_W-1:0] L_AV    = CNT_W'((T_AV    > 1) ? T_AV    - 1 : 0);
    localparam logic [CNT_W-1:0] L_MORTO = CNT_W'((T_MORTO > 1) ? T_MORTO - 1 : 0);

    state_t           state, nxt, proximo, nxt_prox;
    logic [CNT_W-1:0] cnt, ld;
    logic             fim;

    assign fim = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PARADO;
            proximo <= PARADO;
            cnt     <= '0;
        end else begin
            state   <= nxt;
            proximo <= nxt_prox;
            cnt     <= (nxt != state) ? ld : (fim ? cnt : cnt - 1'b1);
        end
    end

    always_comb begin
        nxt      = PARADO;
        nxt_prox = proximo;
        case (state)
            PARADO, FRENTE: begin
                if (bus.FrenteAtras) begin
`ifdef SEQ_DEADTIME_EN
                    nxt      = (state == FRENTE) ? PAUSA : RE;
                    nxt_prox = RE;
`else
                    nxt      = RE;
`endif
                end else if (bus.AtrasFrente) begin
                    nxt = (state == FRENTE) ? FRENTE : AVANCO;
                end else if (bus.Frente) begin
                    nxt = FRENTE;
                end
            end
            PAUSA: nxt = fim ? proximo : PAUSA;
            RE: begin
                if (fim) begin
`ifdef SEQ_DEADTIME_EN
                    nxt      = PAUSA;
                    nxt_prox = GIRO;
`else
                    nxt      = GIRO;
`endif
                end else begin
                    nxt = RE;
                end
            end
            GIRO:    nxt = fim ? PARADO : GIRO;
            AVANCO:  nxt = fim ? PARADO : AVANCO;
            default: nxt = PARADO;
        endcase
        ld = (nxt == PAUSA)  ? L_MORTO :
             (nxt == RE)     ? L_RE    :
             (nxt == GIRO)   ? L_GIRO  :
             (nxt == AVANCO) ? L_AV    : '0;
    end

    always_comb begin
        bus.me_fwd  = (state == FRENTE) || (state == GIRO) || (state == AVANCO);
        bus.me_rev  = (state == RE);
        bus.md_fwd  = (state == FRENTE) || (state == AVANCO);
        bus.md_rev  = (state == RE) || (state == GIRO);
        bus.ocupado = (state == PAUSA) || (state == RE) || (state == GIRO) || (state == AVANCO);
        bus.estado  = state;
    end
endmodule
